// File: rtl/reg_writeback_arbiter.sv
// Write-side front end for the 16-entry register file: round-robin arbitration of ALU and
// load results into a small FIFO, drained as one registered register-file write per cycle.
module reg_writeback_arbiter #(
    parameter int N     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_valid,
    input  logic [3:0]   alu_dest,
    input  logic [N-1:0] alu_data,
    output logic         alu_ready,
    input  logic         mem_valid,
    input  logic [3:0]   mem_dest,
    input  logic [N-1:0] mem_data,
    output logic         mem_ready,
    input  logic         wb_stall,
    output logic         reg_write_en,
    output logic [3:0]   reg_write_dest,
    output logic [N-1:0] reg_write_data,
    output logic [15:0]  pending_mask,
    output logic         busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic          last_grant_reg;   // 1 = mem was granted most recently

    logic [3:0]    fifo_dest [DEPTH];
    logic [N-1:0]  fifo_data [DEPTH];

    logic          pop;
    logic          space;
    logic          alu_grant;
    logic          mem_grant;
    logic          push;
    logic [3:0]    push_dest;
    logic [N-1:0]  push_data;
    logic [DEPTH-1:0] occupied;

    assign pop   = (count_reg != '0) && !wb_stall;
    assign space = (count_reg < CW'(DEPTH)) || pop;

    // On a tie, the producer that lost last time wins this time.
    assign alu_grant = space && alu_valid && (!mem_valid || last_grant_reg);
    assign mem_grant = space && mem_valid && (!alu_valid || !last_grant_reg);
    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    // Writes to register 0 complete the handshake but are discarded here.
    always_comb begin
        push      = 1'b0;
        push_dest = alu_dest;
        push_data = alu_data;
        if (alu_grant) begin
            push = (alu_dest != 4'd0);
        end else if (mem_grant) begin
            push      = (mem_dest != 4'd0);
            push_dest = mem_dest;
            push_data = mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            last_grant_reg <= 1'b1;
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg       <= head_reg + 1'b1;
                reg_write_en   <= 1'b1;
                reg_write_dest <= fifo_dest[head_reg];
                reg_write_data <= fifo_data[head_reg];
            end else begin
                reg_write_en   <= 1'b0;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (alu_grant) begin
                last_grant_reg <= 1'b0;
            end else if (mem_grant) begin
                last_grant_reg <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: occupancy is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest[tail_reg] <= push_dest;
            fifo_data[tail_reg] <= push_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
            logic [PW-1:0] rel;
            assign rel          = PW'(gi) - head_reg;
            assign occupied[gi] = ({1'b0, rel} < count_reg);
        end
    endgenerate

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i]) begin
                pending_mask = pending_mask | (16'(1) << fifo_dest[i]);
            end
        end
        if (reg_write_en) begin
            pending_mask = pending_mask | (16'(1) << reg_write_dest);
        end
    end

    assign busy = (count_reg != '0) || reg_write_en;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed plus random checks of reg_writeback_arbiter against a queue-based reference model.
module tb_reg_writeback_arbiter;
    localparam int N     = 24;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         alu_valid, mem_valid, wb_stall;
    logic [3:0]   alu_dest, mem_dest;
    logic [N-1:0] alu_data, mem_data;
    logic         alu_ready, mem_ready;
    logic         reg_write_en;
    logic [3:0]   reg_write_dest;
    logic [N-1:0] reg_write_data;
    logic [15:0]  pending_mask;
    logic         busy;

    always #5 clk = ~clk;

    reg_writeback_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_stall(wb_stall),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .pending_mask(pending_mask), .busy(busy)
    );

    typedef struct packed {
        logic [3:0]   d;
        logic [N-1:0] v;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // Reference model: the queue holds accepted results in acceptance order.
    ent_t         q[$];
    logic         m_last;
    logic         m_en;
    logic [3:0]   m_dest;
    logic [N-1:0] m_data;
    logic         e_ar, e_mr;
    logic [3:0]   wr_log[$];
    logic         g_log[$];
    logic [N-1:0] dut_rf [16];

    always @(posedge clk) begin
        if (reg_write_en) dut_rf[reg_write_dest] <= reg_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 1'b1;
        m_en   = 1'b0;
        m_dest = '0;
        m_data = '0;
    endtask

    task automatic predict();
        int  cnt;
        bit  sp;
        cnt  = q.size();
        sp   = (cnt < DEPTH) || (cnt > 0 && !wb_stall);
        e_ar = sp && alu_valid && (!mem_valid || m_last);
        e_mr = sp && mem_valid && (!alu_valid || !m_last);
    endtask

    task automatic check_state();
        logic [15:0] m;
        m = '0;
        foreach (q[i]) m[q[i].d] = 1'b1;
        if (m_en) m[m_dest] = 1'b1;
        check("write_en", reg_write_en, m_en);
        check("write_dest", reg_write_dest, m_dest);
        check("write_data", reg_write_data, m_data);
        check("pending_mask", pending_mask, m);
        check("busy", busy, (q.size() != 0) || m_en);
        if (reg_write_en) wr_log.push_back(reg_write_dest);
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        predict();
        check_state();
        check("alu_ready", alu_ready, e_ar);
        check("mem_ready", mem_ready, e_mr);
        @(posedge clk);
        if (q.size() > 0 && !wb_stall) begin
            e      = q.pop_front();
            m_en   = 1'b1;
            m_dest = e.d;
            m_data = e.v;
        end else begin
            m_en = 1'b0;
        end
        if (e_ar) begin
            m_last = 1'b0;
            g_log.push_back(1'b0);
            if (alu_dest != 4'd0) q.push_back('{d: alu_dest, v: alu_data});
        end else if (e_mr) begin
            m_last = 1'b1;
            g_log.push_back(1'b1);
            if (mem_dest != 4'd0) q.push_back('{d: mem_dest, v: mem_data});
        end
        #1;
    endtask

    task automatic do_reset();
        alu_valid = 0; mem_valid = 0; wb_stall = 0;
        alu_dest = '0; mem_dest = '0; alu_data = '0; mem_data = '0;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_en", reg_write_en, 1'b0);
        check("rst_mask", pending_mask, 16'h0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int ai, mi, k, n;
        rst = 1'b1;
        alu_valid = 0; mem_valid = 0; wb_stall = 0;
        alu_dest = '0; mem_dest = '0; alu_data = '0; mem_data = '0;
        for (int i = 0; i < 16; i++) dut_rf[i] = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_dest", reg_write_dest, 4'd0);
        check("reset_data", reg_write_data, '0);
        do_reset();

        // Single ALU result: write appears two edges after presentation.
        alu_valid = 1; alu_dest = 4'd4; alu_data = 24'h00ABCD;
        #1 check("single_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 0;
        #1;
        check("single_e1_mask", pending_mask, 16'h0010);
        check("single_e1_en", reg_write_en, 1'b0);
        tick();
        check("single_e2_en", reg_write_en, 1'b1);
        check("single_e2_dest", reg_write_dest, 4'd4);
        check("single_e2_data", reg_write_data, 24'h00ABCD);
        check("single_e2_mask", pending_mask, 16'h0010);
        tick();
        check("single_e3_en", reg_write_en, 1'b0);
        check("single_e3_mask", pending_mask, 16'h0000);
        check("single_e3_busy", busy, 1'b0);

        // Round-robin with both producers holding until accepted.
        do_reset();
        g_log.delete(); wr_log.delete();
        ai = 0; mi = 0;
        alu_valid = 1; alu_dest = 4'd5; alu_data = 24'h000055;
        mem_valid = 1; mem_dest = 4'd7; mem_data = 24'h000077;
        n = 0;
        while ((alu_valid || mem_valid) && n < 12) begin
            tick();
            n++;
            if (e_ar) begin
                ai++;
                if (ai == 2) alu_valid = 0; else begin alu_dest = 4'd6; alu_data = 24'h000066; end
            end
            if (e_mr) begin
                mi++;
                if (mi == 2) mem_valid = 0; else begin mem_dest = 4'd8; mem_data = 24'h000088; end
            end
        end
        alu_valid = 0; mem_valid = 0;
        repeat (5) tick();
        check("rr_grant_count", g_log.size(), 4);
        for (int i = 0; i < 4 && i < g_log.size(); i++) check("rr_grant_order", g_log[i], i % 2);
        check("rr_write_count", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check("rr_write_order", wr_log[i], (i == 0) ? 5 : (i == 1) ? 7 : (i == 2) ? 6 : 8);

        // Fill under stall, then drain.
        do_reset();
        wr_log.delete();
        wb_stall = 1;
        k = 0;
        alu_valid = 1; alu_dest = 4'd4; alu_data = 24'h000104;
        repeat (5) begin
            tick();
            if (e_ar) begin
                k++;
                alu_dest = 4'(4 + k);
                alu_data = 24'h000100 + 24'(4 + k);
            end
        end
        check("fill_accepted", k, 4);
        #1;
        check("fill_full_ready", alu_ready, 1'b0);
        check("fill_mask", pending_mask, 16'h00F0);
        wb_stall = 0;
        #1 check("fill_drain_ready", alu_ready, 1'b1);
        n = 0;
        while (k < 5 && n < 5) begin
            tick();
            n++;
            if (e_ar) k++;
        end
        alu_valid = 0;
        repeat (6) tick();
        check("fill_write_count", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) check("fill_write_order", wr_log[i], 4 + i);

        // Destination 0 handshakes but never writes.
        do_reset();
        mem_valid = 1; mem_dest = 4'd0; mem_data = 24'hFFFFFF;
        #1 check("zero_ready", mem_ready, 1'b1);
        tick();
        mem_valid = 0;
        repeat (3) begin
            tick();
            check("zero_en", reg_write_en, 1'b0);
            check("zero_mask", pending_mask, 16'h0);
            check("zero_busy", busy, 1'b0);
        end

        // Two writes to the same register commit oldest first.
        do_reset();
        wr_log.delete();
        alu_valid = 1; alu_dest = 4'd9; alu_data = 24'h000001;
        tick();
        alu_valid = 0;
        mem_valid = 1; mem_dest = 4'd9; mem_data = 24'h000002;
        tick();
        mem_valid = 0;
        repeat (4) tick();
        check("same_write_count", wr_log.size(), 2);
        check("same_final_value", dut_rf[9], 24'h000002);

        // Asynchronous reset with a write on the port and entries queued.
        do_reset();
        wb_stall = 1;
        alu_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            alu_dest = 4'(i);
            alu_data = 24'h000A00 + 24'(i);
            tick();
        end
        alu_valid = 0;
        wb_stall = 0;
        tick();
        check("midrst_pre_en", reg_write_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_en", reg_write_en, 1'b0);
        check("midrst_mask", pending_mask, 16'h0);
        check("midrst_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        wr_log.delete();
        repeat (6) tick();
        check("midrst_no_stale", wr_log.size(), 0);

        // Randomized traffic; producers hold their offer until accepted.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!alu_valid || e_ar) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_dest  = 4'($urandom_range(0, 15));
                alu_data  = 24'($urandom);
            end
            if (!mem_valid || e_mr) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_dest  = 4'($urandom_range(0, 15));
                mem_data  = 24'($urandom);
            end
            wb_stall = ($urandom_range(0, 3) == 0);
        end
        alu_valid = 0; mem_valid = 0; wb_stall = 0;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_writeback_arbiter.md
# reg_writeback_arbiter

Write-side front end for the 16-entry, N-bit processor register file. It accepts results from two producers, the ALU and the memory-load unit, over valid/ready handshakes. It queues accepted results in a small FIFO and drives exactly one register-file write per cycle through a registered write port (`reg_write_en`, `reg_write_dest`, `reg_write_data`). It also exports a pending-destination mask so the hazard logic can stall reads of registers that still have writes in flight.

## Interface
- `N`, 24, data width; matches the register-file width.
- `DEPTH`, 4, FIFO entries; must be a power of two and at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `alu_valid`  in  1  ALU result available.
- `alu_dest`  in  4  ALU destination register index.
- `alu_data`  in  N  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `mem_valid`  in  1  load result available.
- `mem_dest`  in  4  load destination register index.
- `mem_data`  in  N  load result.
- `mem_ready`  out  1  load result accepted this cycle.
- `wb_stall`  in  1  freeze draining; FIFO holds and no write is issued.
- `reg_write_en`  out  1  write strobe to the register file.
- `reg_write_dest`  out  4  register-file write index.
- `reg_write_data`  out  N  register-file write data.
- `pending_mask`  out  16  bit d is 1 while any queued or issuing write targets register d.
- `busy`  out  1  FIFO is non-empty or `reg_write_en` is high.

## Operation
**Space and pop**
- `space` = (count < DEPTH) or `pop`.
- `pop` = (count > 0) and not `wb_stall`.

**Round-robin grant**
- At most one producer is granted per cycle, and only when `space` is 1.
- If exactly one producer is valid, that producer is granted.
- If both are valid, grant the producer that was not granted most recently. A `last_grant` flag is updated on every grant.
- `alu_ready` and `mem_ready` equal their grant bits. They are combinational from the valid inputs, `count` and `wb_stall`.

**Enqueue**
- A granted result with a nonzero destination is written at the tail.
- A granted result with destination 0 completes its handshake but is not enqueued, because register 0 is hardwired zero. It still updates `last_grant`.

**Output stage (registered)**
- On each edge with `pop` = 1: load `reg_write_dest`/`reg_write_data` from the head, set `reg_write_en` to 1, and advance the head.
- On each edge with `pop` = 0: clear `reg_write_en`. Dest/data hold their previous values.

**FIFO bookkeeping**
- Push and pop in the same cycle leave `count` unchanged.
- Head and tail pointers wrap modulo DEPTH.

**pending_mask**
- OR of one-hot(dest) over all valid FIFO entries, plus one-hot(`reg_write_dest`) when `reg_write_en` is 1.
- Combinational from registered state only.

**Register 15 (pc)** is treated like any other destination; no special ordering is applied.

## Timing
- **Reset values:** `reg_write_en` 0, `reg_write_dest` 0, `reg_write_data` 0, `pending_mask` 0, `busy` 0, `count` 0, both pointers 0.
- **`last_grant` at reset** = mem, so the ALU wins the first tie.
- **Latency:** a result accepted at edge k with the FIFO empty and no stall appears with `reg_write_en` = 1 in the cycle after edge k+1. The register file commits it at edge k+2.
- **Throughput:** one write per cycle sustained.
- **Full FIFO with `wb_stall` = 1:** both readies are 0 and producers must hold their valid, dest and data.
- **Full FIFO with `wb_stall` = 0:** a push is still allowed, since the simultaneous pop frees an entry.
- **Ordering:** writes issue strictly in acceptance order. Two writes to the same register therefore commit oldest first.
- **Reset mid-operation:** all queued results are dropped, outputs return to reset values immediately, and a write already on the port is cancelled.

## Test plan
- **Single ALU result:** reset, then `alu_valid`=1, dest=4, data=0x00ABCD for one cycle. Required: `alu_ready`=1 that cycle; `reg_write_en`=1 with dest 4 and data 0x00ABCD exactly 2 edges later for one cycle; `pending_mask`=0x0010 from edge 1 through edge 2 inclusive, then 0.
- **Round-robin:** both producers valid for 4 cycles (ALU dests 5,6; mem dests 7,8 held until accepted). Required: grants alternate ALU, mem, ALU, mem; write order is 5, 7, 6, 8.
- **Fill under stall:** `wb_stall`=1 and 5 ALU results to dests 4..8. Required: first 4 accepted, then `alu_ready`=0; `pending_mask`=0x00F0. Release the stall: writes 4,5,6,7 issue on consecutive cycles, and dest 8 is accepted in the first drain cycle.
- **Zero destination:** mem result with dest 0 and data 0xFFFFFF. Required: `mem_ready`=1, no `reg_write_en` pulse, `pending_mask` stays 0, `busy` stays 0.
- **Same-register ordering:** ALU writes dest 9 with 0x000001, then mem writes dest 9 with 0x000002. Required: two writes in that order with dest 9; final register value 0x000002.
- **Reset mid-operation:** 3 entries queued under stall, then assert `rst` asynchronously mid-cycle. Required: `reg_write_en`, `pending_mask` and `busy` go to 0 without waiting for an edge; after release, no stale writes issue.
